decode: RTL

Second pipeline stage of the RV32I core. Consumes the instruction/PC pair produced by `fetch`, reads the 32×32 register file, expands immediates and generates control for execute. Detects load-use hazards and drives the one-cycle stall request back to fetch, replaying the stalled instruction from an internal hold buffer. Owns the register file; writeback enters through a dedicated write port.

---
 rtl/decode.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/decode.sv
// decode: second stage of the RV32I pipeline.
// Decodes the instruction from fetch, or the held instruction while replaying
// after a load-use stall. It reads the register file and expands the
// immediate, then registers the execute bundle on the ex_* outputs.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   instr_in, pc_in   instruction/PC from fetch, qualified by instr_valid
//   flush             redirect from execute; kills the instruction in decode
//   wb_en/wb_rd/wb_data  register-file write port
//   bubble_to_fetch   combinational load-use stall request to fetch
//   ex_*              registered execute-stage bundle
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        instr_valid,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        bubble_to_fetch,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {NORMAL = 1'b0, REPLAY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        hold_valid;
  logic [31:0] hold_instr, hold_pc;
  logic [31:0] regs [32];

  logic [31:0] src_instr, src_pc;
  logic        src_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic signed [31:0] imm;
  logic        legal, use_rs1, use_rs2, writes_rd, mem_read, mem_write;
  logic        load_in_ex, hazard, issue;

  // While replaying, instr_in is ignored; fetch re-presents it next cycle.
  assign src_instr = (state_q == REPLAY) ? hold_instr : instr_in;
  assign src_pc    = (state_q == REPLAY) ? hold_pc    : pc_in;
  assign src_valid = (state_q == REPLAY) ? hold_valid : instr_valid;

  assign opcode = src_instr[6:0];
  assign rd     = src_instr[11:7];
  assign rs1    = src_instr[19:15];
  assign rs2    = src_instr[24:20];

  always_comb begin
    imm       = '0;
    legal     = 1'b1;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (opcode)
      OP_LOAD: begin
        imm       = $signed({{20{src_instr[31]}}, src_instr[31:20]});
        writes_rd = 1'b1;
        mem_read  = 1'b1;
      end
      OP_OPIMM, OP_JALR: begin
        imm       = $signed({{20{src_instr[31]}}, src_instr[31:20]});
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        imm       = $signed({{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]});
        use_rs2   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BRANCH: begin
        imm     = $signed({{19{src_instr[31]}}, src_instr[31], src_instr[7],
                           src_instr[30:25], src_instr[11:8], 1'b0});
        use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm       = $signed({src_instr[31:12], 12'b0});
        use_rs1   = 1'b0;
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm       = $signed({{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                             src_instr[20], src_instr[30:21], 1'b0});
        use_rs1   = 1'b0;
        writes_rd = 1'b1;
      end
      OP_OP: begin
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      default: begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
      end
    endcase
  end

  // Register-file read with same-cycle writeback bypass; x0 is hardwired.
  assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

  // Load-use: the load now in execute produces a register this source reads.
  // In REPLAY execute holds a bubble, so the state test is only a guard.
  assign load_in_ex = ex_valid && ex_mem_read && (ex_rd != 5'd0);
  assign hazard = load_in_ex && src_valid && (state_q == NORMAL) && !flush &&
                  ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
  assign bubble_to_fetch = hazard;
  assign issue = src_valid && !flush && !hazard;

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (hazard) state_d = REPLAY;
      REPLAY:  state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    if (flush) state_d = NORMAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      hold_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush)                 hold_valid <= 1'b0;
      else if (hazard)           hold_valid <= 1'b1;
      else if (state_q == REPLAY) hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (hazard) begin
      hold_instr <= src_instr;
      hold_pc    <= src_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ---- stage boundary: decode -> execute ----
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= src_pc;
      ex_opcode    <= opcode;
      ex_funct3    <= src_instr[14:12];
      ex_funct7b5  <= src_instr[30];
      ex_rd        <= rd;
      ex_rs1_data  <= rs1_data;
      ex_rs2_data  <= rs2_data;
      ex_imm       <= imm;
      ex_reg_write <= legal && writes_rd && (rd != 5'd0);
      ex_mem_read  <= legal && mem_read;
      ex_mem_write <= legal && mem_write;
      ex_illegal   <= !legal;
    end
  end
endmodule
